model_buck_boost_mch: RTL and testbench

Time-multiplexed, N-channel fixed-point buck-boost plant model for hardware-in-the-loop benches. Each channel is an independent converter with its own L/C/R coefficients, switch command and input voltage. One shared datapath iterates over all channels on every `ce` step. Per-channel inductor current and output voltage are streamed out with channel tags, and all arithmetic saturates instead of wrapping.

---
 rtl/model_buck_boost_mch_if.sv | 34 +++
 rtl/model_buck_boost_mch.sv | 239 +++++++++++++++++++++++
 tb/tb_model_buck_boost_mch.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/model_buck_boost_mch_if.sv
// Control, coefficient-write and result-stream bundle for model_buck_boost_mch.
// master drives step/config requests; slave is the plant model.
interface model_buck_boost_mch_if #(
    parameter int MODEL_DATA_WIDTH = 32,
    parameter int N_CH             = 4
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                               ce;
    logic        [N_CH-1:0]             s1;
    logic                               cfg_we;
    logic        [CH_W-1:0]             cfg_ch;
    logic        [2:0]                  cfg_sel;
    logic signed [MODEL_DATA_WIDTH-1:0] cfg_data;
    logic                               cfg_drop;
    logic                               busy;
    logic                               overrun;
    logic                               out_valid;
    logic        [CH_W-1:0]             out_ch;
    logic signed [MODEL_DATA_WIDTH-1:0] iL_o;
    logic signed [MODEL_DATA_WIDTH-1:0] vO_o;
    logic                               done;
    logic                               sat;

    modport master (
        output ce, s1, cfg_we, cfg_ch, cfg_sel, cfg_data,
        input  cfg_drop, busy, overrun, out_valid, out_ch, iL_o, vO_o, done, sat
    );

    modport slave (
        input  ce, s1, cfg_we, cfg_ch, cfg_sel, cfg_data,
        output cfg_drop, busy, overrun, out_valid, out_ch, iL_o, vO_o, done, sat
    );
endinterface

// File: rtl/model_buck_boost_mch.sv
// Time-multiplexed N-channel saturating fixed-point buck-boost plant model (3 cycles per channel).
// Define MODEL_BB_DCM_EN to clamp positive inductor current to 0 while the switch is open.
module model_buck_boost_mch #(
    parameter int MODEL_DATA_WIDTH         = 32,
    parameter int MODEL_DATA_WIDTH_DECIMAL = 24,
    parameter int N_CH                     = 4
) (
    input logic                   aclk,
    input logic                   resetn,
    model_buck_boost_mch_if.slave bus
);
    localparam int W    = MODEL_DATA_WIDTH;
    localparam int D    = MODEL_DATA_WIDTH_DECIMAL;
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0]     LAST_CH = CH_W'(N_CH - 1);
    localparam logic signed [W-1:0] MAX_W   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_W   = {1'b1, {(W-1){1'b0}}};

    typedef logic signed [W-1:0]   word_t;
    typedef logic signed [2*W-1:0] wide_t;
    typedef enum logic [1:0] {ST_IDLE, ST_PA, ST_PB, ST_PC} state_t;

    function automatic wide_t ext(input word_t a);
        return {{W{a[W-1]}}, a};
    endfunction

    // Result is {saturated_flag, value}; a value fits when its top W+1 bits are all equal.
    function automatic logic [W:0] clamp(input wide_t x);
        logic [W:0] r;
        if ((x[2*W-1:W-1] == '0) || (x[2*W-1:W-1] == '1)) begin
            r = {1'b0, x[W-1:0]};
        end else if (x[2*W-1]) begin
            r = {1'b1, MIN_W};
        end else begin
            r = {1'b1, MAX_W};
        end
        return r;
    endfunction

    function automatic logic [W:0] mul_sat(input word_t a, input word_t b);
        wide_t p;
        p = ext(a) * ext(b);
        return clamp(p >>> D);
    endfunction

    function automatic logic [W:0] sub_sat(input word_t a, input word_t b);
        return clamp(ext(a) - ext(b));
    endfunction

    function automatic logic [W:0] add3_sat(input word_t a, input word_t b, input word_t c);
        return clamp(ext(a) + ext(b) + ext(c));
    endfunction

    state_t          state_reg, state_next;
    logic [CH_W-1:0] ch_reg, ch_next;
    logic [N_CH-1:0] s1_cap_reg;
    word_t           vrl_reg, io_reg;
    logic            sat_pa_reg;
    logic            out_valid_reg, done_reg, sat_reg, overrun_reg, cfg_drop_reg;
    logic [CH_W-1:0] out_ch_reg;
    word_t           il_o_reg, vo_o_reg;

    word_t kl_arr [N_CH];
    word_t kc_arr [N_CH];
    word_t kr_arr [N_CH];
    word_t krl_arr[N_CH];
    word_t krc_arr[N_CH];
    word_t vdc_arr[N_CH];
    word_t il_arr [N_CH];
    word_t vo_arr [N_CH];

    logic busy, accept_ce, cfg_accept, wb_en, ch_in_range;

    assign busy        = (state_reg != ST_IDLE);
    assign accept_ce   = (state_reg == ST_IDLE) && bus.ce;
    assign wb_en       = (state_reg == ST_PB);
    assign ch_in_range = ({1'b0, bus.cfg_ch} < (CH_W+1)'(N_CH));
    // Coefficients only change between steps, so a running step sees one consistent set.
    assign cfg_accept  = bus.cfg_we && !busy && (bus.cfg_sel <= 3'd5) && ch_in_range;

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.ce) begin
                    state_next = ST_PA;
                    ch_next    = '0;
                end
            end
            ST_PA: state_next = ST_PB;
            ST_PB: state_next = ST_PC;
            ST_PC: begin
                if (ch_reg == LAST_CH) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_PA;
                    ch_next    = ch_reg + CH_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operands of the channel being processed.
    word_t il_cur, vo_cur, kl_cur, kc_cur, kr_cur, krl_cur, krc_cur, vdc_cur;
    logic  s1_cur;
    assign il_cur  = il_arr[ch_reg];
    assign vo_cur  = vo_arr[ch_reg];
    assign kl_cur  = kl_arr[ch_reg];
    assign kc_cur  = kc_arr[ch_reg];
    assign kr_cur  = kr_arr[ch_reg];
    assign krl_cur = krl_arr[ch_reg];
    assign krc_cur = krc_arr[ch_reg];
    assign vdc_cur = vdc_arr[ch_reg];
    assign s1_cur  = s1_cap_reg[ch_reg];

    // Resistor drops, registered at the end of PA.
    word_t vrl, io;
    logic  f_vrl, f_io;
    assign {f_vrl, vrl} = mul_sat(il_cur, krl_cur);
    assign {f_io, io}   = mul_sat(vo_cur, kr_cur);

    // Branch quantities and integrator update; results land in the output/state registers
    // on entry to PC so they are visible during the channel's PC cycle.
    word_t vl, ic, vrc, dl, dc, il_next, vo_next, il_store;
    logic  f_vl, f_ic, f_vrc, f_dl, f_dc, f_il, f_vo, sat_pb;
    assign {f_vl, vl}       = s1_cur ? sub_sat(vdc_cur, vrl_reg) : sub_sat(vo_cur, vrl_reg);
    assign {f_ic, ic}       = s1_cur ? sub_sat('0, io_reg) : sub_sat(il_cur, io_reg);
    assign {f_vrc, vrc}     = mul_sat(ic, krc_cur);
    assign {f_dl, dl}       = mul_sat(vl, kl_cur);
    assign {f_il, il_next}  = sub_sat(il_cur, dl);
    assign {f_dc, dc}       = mul_sat(ic, kc_cur);
    assign {f_vo, vo_next}  = add3_sat(vo_cur, dc, vrc);
    assign sat_pb = sat_pa_reg | f_vl | f_ic | f_vrc | f_dl | f_il | f_dc | f_vo;

`ifdef MODEL_BB_DCM_EN
    // Diode blocks reverse conduction: with the switch open the current may not turn positive.
    assign il_store = (!s1_cur && !il_next[W-1] && (il_next != '0)) ? '0 : il_next;
`else
    assign il_store = il_next;
`endif

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        word_t kl_reg, kc_reg, kr_reg, krl_reg, krc_reg, vdc_reg, il_reg, vo_reg;
        logic  hit_cfg, hit_wb;

        assign hit_cfg = cfg_accept && (bus.cfg_ch == CH_W'(gi));
        assign hit_wb  = wb_en && (ch_reg == CH_W'(gi));

        always_ff @(posedge aclk or negedge resetn) begin
            if (!resetn) begin
                kl_reg  <= '0;
                kc_reg  <= '0;
                kr_reg  <= '0;
                krl_reg <= '0;
                krc_reg <= '0;
                vdc_reg <= '0;
                il_reg  <= '0;
                vo_reg  <= '0;
            end else begin
                if (hit_cfg) begin
                    case (bus.cfg_sel)
                        3'd0:    kl_reg  <= bus.cfg_data;
                        3'd1:    kc_reg  <= bus.cfg_data;
                        3'd2:    kr_reg  <= bus.cfg_data;
                        3'd3:    krl_reg <= bus.cfg_data;
                        3'd4:    krc_reg <= bus.cfg_data;
                        3'd5:    vdc_reg <= bus.cfg_data;
                        default: ;
                    endcase
                end
                if (hit_wb) begin
                    il_reg <= il_store;
                    vo_reg <= vo_next;
                end
            end
        end

        assign kl_arr[gi]  = kl_reg;
        assign kc_arr[gi]  = kc_reg;
        assign kr_arr[gi]  = kr_reg;
        assign krl_arr[gi] = krl_reg;
        assign krc_arr[gi] = krc_reg;
        assign vdc_arr[gi] = vdc_reg;
        assign il_arr[gi]  = il_reg;
        assign vo_arr[gi]  = vo_reg;
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            ch_reg        <= '0;
            s1_cap_reg    <= '0;
            vrl_reg       <= '0;
            io_reg        <= '0;
            sat_pa_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            sat_reg       <= 1'b0;
            out_ch_reg    <= '0;
            il_o_reg      <= '0;
            vo_o_reg      <= '0;
            overrun_reg   <= 1'b0;
            cfg_drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            if (accept_ce) begin
                s1_cap_reg <= bus.s1;
            end
            if (state_reg == ST_PA) begin
                vrl_reg    <= vrl;
                io_reg     <= io;
                sat_pa_reg <= f_vrl | f_io;
            end
            out_valid_reg <= wb_en;
            done_reg      <= wb_en && (ch_reg == LAST_CH);
            sat_reg       <= wb_en && sat_pb;
            if (wb_en) begin
                out_ch_reg <= ch_reg;
                il_o_reg   <= il_store;
                vo_o_reg   <= vo_next;
            end
            overrun_reg  <= bus.ce && busy;
            cfg_drop_reg <= bus.cfg_we && !cfg_accept;
        end
    end

    assign bus.busy      = busy;
    assign bus.overrun   = overrun_reg;
    assign bus.cfg_drop  = cfg_drop_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.iL_o      = il_o_reg;
    assign bus.vO_o      = vo_o_reg;
    assign bus.done      = done_reg;
    assign bus.sat       = sat_reg;
endmodule

// File: tb/tb_model_buck_boost_mch.sv
// Directed + randomized bench for model_buck_boost_mch against an integer-arithmetic plant model.
module tb_model_buck_boost_mch;
    localparam int W    = 32;
    localparam int D    = 24;
    localparam int N_CH = 4;
    localparam int CH_W = 2;
    localparam int NCYC = 3 * N_CH;
    localparam longint MAXV = 64'sh7FFFFFFF;
    localparam longint MINV = -64'sh80000000;

    logic aclk   = 1'b0;
    logic resetn = 1'b0;
    always #5 aclk = ~aclk;

    model_buck_boost_mch_if #(.MODEL_DATA_WIDTH(W), .N_CH(N_CH)) bus ();

    model_buck_boost_mch #(
        .MODEL_DATA_WIDTH(W),
        .MODEL_DATA_WIDTH_DECIMAL(D),
        .N_CH(N_CH)
    ) dut (
        .aclk(aclk),
        .resetn(resetn),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: coefficient index 0 kL, 1 kC, 2 kR, 3 kRL, 4 kRC, 5 vdc
    longint m_il[N_CH];
    longint m_vo[N_CH];
    longint m_k[N_CH][6];
    longint exp_il[N_CH];
    longint exp_vo[N_CH];
    bit     exp_sat[N_CH];
    bit     m_flag;
    logic [31:0] obs_il[N_CH];
    logic [31:0] obs_vo[N_CH];
    logic        obs_sat[N_CH];

    task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    function automatic longint clampv(input longint x);
        if (x > MAXV) begin
            m_flag = 1'b1;
            return MAXV;
        end
        if (x < MINV) begin
            m_flag = 1'b1;
            return MINV;
        end
        return x;
    endfunction

    function automatic longint fxmul(input longint a, input longint b);
        return clampv((a * b) >>> D);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_il[c] = 0;
            m_vo[c] = 0;
            for (int s = 0; s < 6; s++) m_k[c][s] = 0;
        end
    endtask

    task automatic model_step(input logic [N_CH-1:0] s1v);
        longint vrl, io, vl, ic, vrc, iln, von;
        for (int c = 0; c < N_CH; c++) begin
            m_flag = 1'b0;
            vrl = fxmul(m_il[c], m_k[c][3]);
            io  = fxmul(m_vo[c], m_k[c][2]);
            vl  = s1v[c] ? clampv(m_k[c][5] - vrl) : clampv(m_vo[c] - vrl);
            ic  = s1v[c] ? clampv(-io) : clampv(m_il[c] - io);
            vrc = fxmul(ic, m_k[c][4]);
            iln = clampv(m_il[c] - fxmul(vl, m_k[c][0]));
            von = clampv(m_vo[c] + fxmul(ic, m_k[c][1]) + vrc);
            exp_sat[c] = m_flag;
`ifdef MODEL_BB_DCM_EN
            if (!s1v[c] && iln > 0) iln = 0;
`endif
            m_il[c] = iln;
            m_vo[c] = von;
            exp_il[c] = iln;
            exp_vo[c] = von;
        end
    endtask

    // Called just after a negedge while idle; the write is sampled at the next rising edge.
    task automatic cfg_write(input int ch, input int sel, input logic [31:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = CH_W'(ch);
        bus.cfg_sel  = 3'(sel);
        bus.cfg_data = data;
        @(negedge aclk);
        bus.cfg_we = 1'b0;
        check_b($sformatf("cfg_drop ch%0d sel%0d", ch, sel), bus.cfg_drop, sel > 5);
        if (sel <= 5) m_k[ch][sel] = longint'($signed(data));
        $display("cfg write ch=%0d sel=%0d data=%h", ch, sel, data);
    endtask

    // One full model step; ce is sampled at edge 0 and cycle k is checked at the negedge
    // before edge k. Optional overrun / dropped-write injection and a ch2 write alongside ce.
    task automatic run_step(input logic [N_CH-1:0] s1v, input int ovr_cyc, input int drop_cyc,
                            input bit co_wr, input int co_sel, input logic [31:0] co_data);
        bit valid;
        int c;
        bus.ce = 1'b1;
        bus.s1 = s1v;
        if (co_wr) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_ch   = CH_W'(2);
            bus.cfg_sel  = 3'(co_sel);
            bus.cfg_data = co_data;
            m_k[2][co_sel] = longint'($signed(co_data));
        end
        model_step(s1v);
        for (int k = 1; k <= NCYC + 1; k++) begin
            @(negedge aclk);
            bus.ce     = 1'b0;
            bus.cfg_we = 1'b0;
            valid = (k <= NCYC) && (k % 3 == 0);
            c = k / 3 - 1;
            check_b($sformatf("busy cyc%0d", k), bus.busy, k <= NCYC);
            check_b($sformatf("out_valid cyc%0d", k), bus.out_valid, valid);
            check_b($sformatf("done cyc%0d", k), bus.done, k == NCYC);
            check_b($sformatf("overrun cyc%0d", k), bus.overrun, (ovr_cyc != 0) && (k == ovr_cyc + 1));
            check_b($sformatf("cfg_drop cyc%0d", k), bus.cfg_drop, (drop_cyc != 0) && (k == drop_cyc + 1));
            if (valid) begin
                check_w($sformatf("out_ch cyc%0d", k), 32'(bus.out_ch), 32'(c));
                check_w($sformatf("iL_o ch%0d", c), bus.iL_o, 32'(exp_il[c]));
                check_w($sformatf("vO_o ch%0d", c), bus.vO_o, 32'(exp_vo[c]));
                check_b($sformatf("sat ch%0d", c), bus.sat, exp_sat[c]);
                obs_il[c]  = bus.iL_o;
                obs_vo[c]  = bus.vO_o;
                obs_sat[c] = bus.sat;
                $display("result ch=%0d iL=%h vO=%h sat=%b", c, bus.iL_o, bus.vO_o, bus.sat);
            end else begin
                check_b($sformatf("sat idle cyc%0d", k), bus.sat, 1'b0);
            end
            if (k == ovr_cyc) bus.ce = 1'b1;
            if (k == drop_cyc) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_ch   = CH_W'(0);
                bus.cfg_sel  = 3'd0;
                bus.cfg_data = 32'h0010_0000;
            end
        end
        bus.ce     = 1'b0;
        bus.cfg_we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_b({tag, " busy"}, bus.busy, 1'b0);
        check_b({tag, " out_valid"}, bus.out_valid, 1'b0);
        check_b({tag, " done"}, bus.done, 1'b0);
        check_b({tag, " sat"}, bus.sat, 1'b0);
        check_b({tag, " overrun"}, bus.overrun, 1'b0);
        check_b({tag, " cfg_drop"}, bus.cfg_drop, 1'b0);
        check_w({tag, " out_ch"}, 32'(bus.out_ch), 32'd0);
        check_w({tag, " iL_o"}, bus.iL_o, 32'd0);
        check_w({tag, " vO_o"}, bus.vO_o, 32'd0);
    endtask

    initial begin
        logic signed [31:0] rnd;
        bus.ce = 1'b0;
        bus.s1 = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_ch = '0;
        bus.cfg_sel = '0;
        bus.cfg_data = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge aclk);
        check_all_zero("reset");
        resetn = 1'b1;
        @(negedge aclk);

        // Reset in the middle of a step
        cfg_write(0, 5, 32'h0100_0000);
        cfg_write(0, 0, 32'h0080_0000);
        cfg_write(3, 1, 32'h0040_0000);
        bus.ce = 1'b1;
        bus.s1 = '1;
        @(negedge aclk);
        bus.ce = 1'b0;
        check_b("midreset busy cyc1", bus.busy, 1'b1);
        repeat (3) @(negedge aclk);
        check_w("midreset iL_o cyc4", bus.iL_o, 32'hFF80_0000);
        resetn = 1'b0;
        #1;
        check_all_zero("midreset");
        $display("reset asserted mid-step");
        @(negedge aclk);
        resetn = 1'b1;
        model_reset();
        @(negedge aclk);
        run_step(4'b1111, 0, 0, 1'b0, 0, 32'd0);

        // Single step, then discontinuous-conduction step
        cfg_write(0, 5, 32'h0100_0000);
        cfg_write(0, 0, 32'h0080_0000);
        run_step(4'b0001, 0, 0, 1'b0, 0, 32'd0);
        check_w("single iL ch0", obs_il[0], 32'hFF80_0000);
        check_w("single vO ch0", obs_vo[0], 32'h0000_0000);
        check_w("single iL ch1", obs_il[1], 32'h0000_0000);
        cfg_write(0, 3, 32'hFC00_0000);
        run_step(4'b0000, 0, 0, 1'b0, 0, 32'd0);
`ifdef MODEL_BB_DCM_EN
        check_w("dcm iL ch0", obs_il[0], 32'h0000_0000);
`else
        check_w("dcm iL ch0", obs_il[0], 32'h0080_0000);
`endif

        // Saturation on ch1: the second step pins the current at the negative rail
        cfg_write(1, 5, 32'h7FFF_FFFF);
        cfg_write(1, 0, 32'h7FFF_FFFF);
        run_step(4'b0010, 0, 0, 1'b0, 0, 32'd0);
        check_b("sat flag ch1", obs_sat[1], 1'b1);
        run_step(4'b0010, 0, 0, 1'b0, 0, 32'd0);
        check_w("sat rail ch1", obs_il[1], 32'h8000_0000);

        // Overrun and dropped write while busy; following step must use the old kL
        cfg_write(0, 3, 32'h0000_0000);
        run_step(4'b0001, 2, 5, 1'b0, 0, 32'd0);
        run_step(4'b0001, 0, 0, 1'b0, 0, 32'd0);
        cfg_write(0, 6, 32'h1234_5678);
        cfg_write(1, 7, 32'h1234_5678);

        // Write landing in the same cycle as ce is used by that step
        cfg_write(2, 0, 32'h0100_0000);
        run_step(4'b0100, 0, 0, 1'b1, 5, 32'h0040_0000);
        check_w("co-write iL ch2", obs_il[2], 32'hFFC0_0000);

        // Channel isolation with random coefficients and switch patterns
        for (int c = 0; c < N_CH; c++) begin
            for (int s = 0; s < 6; s++) begin
                rnd = $urandom();
                rnd = rnd >>> $urandom_range(6, 10);
                cfg_write(c, s, rnd);
            end
        end
        for (int n = 0; n < 10; n++) begin
            run_step(N_CH'($urandom_range(0, (1 << N_CH) - 1)), 0, 0, 1'b0, 0, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
